// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the REGFILE write port between priority WB and a queued AUX unit
module regfile_write_arbiter #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wbValid,
   input  logic [4:0]               wbRd,
   input  logic [XLEN-1:0]          wbData,
   input  logic                     auxValid,
   output logic                     auxReady,
   input  logic [4:0]               auxRd,
   input  logic [XLEN-1:0]          auxData,
   output logic                     regWrite,
   output logic [4:0]               writeReg,
   output logic [XLEN-1:0]          writeData,
   output logic [31:0]              pendMask,
   output logic                     wbStall,
   output logic [$clog2(DEPTH):0]   fifoCount
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

   logic [4:0]      rd_q   [DEPTH];
   logic [4:0]      rd_d   [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] live_q, live_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            reg_write_q, reg_write_d;
   logic [4:0]      write_reg_q, write_reg_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   state_t          state_q, state_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic            push, pop, kill, blocked;

   assign auxReady  = rstn && (count_q != CW'(DEPTH));
   assign push      = auxValid && auxReady && (auxRd != 5'd0);
   assign pop       = !wbValid && (count_q != '0);
   assign kill      = wbValid && (wbRd != 5'd0);
   assign blocked   = wbValid && (count_q != '0);
   assign regWrite  = reg_write_q;
   assign writeReg  = write_reg_q;
   assign writeData = write_data_q;
   assign fifoCount = count_q;

   // FIFO update: WB kills older matching entries, pop frees the head, push fills the tail
   always_comb begin
      rd_d   = rd_q;
      data_d = data_q;
      live_d = live_q;
      head_d = head_q;
      tail_d = tail_q;
      for (int i = 0; i < DEPTH; i++)
         if (kill && (rd_q[i] == wbRd)) live_d[i] = 1'b0;
      if (pop) begin
         live_d[head_q] = 1'b0;
         head_d         = head_q + AW'(1);
      end
      if (push) begin
         live_d[tail_q] = 1'b1;
         rd_d[tail_q]   = auxRd;
         data_d[tail_q] = auxData;
         tail_d         = tail_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // FIFO state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
         live_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         data_q  <= data_d;
         live_q  <= live_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Port schedule: WB first, else drain the head (dead entries write nothing), else idle and hold
   always_comb begin
      reg_write_d  = wbValid ? (wbRd != 5'd0) : pop && live_q[head_q] && (rd_q[head_q] != 5'd0);
      write_reg_d  = wbValid ? wbRd : pop ? rd_q[head_q] : write_reg_q;
      write_data_d = wbValid ? wbData : pop ? data_q[head_q] : write_data_q;
   end

   // Registered REGFILE write port
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // Live entries advertise their destination for decode hazard detection
   always_comb begin
      pendMask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (live_q[i]) pendMask[rd_q[i]] = 1'b1;
   end

   // Starvation FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Starvation FSM next state: count blocked cycles, force one bubble at the limit
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            state_d = blocked ? S_WAIT : S_IDLE;
            cnt_d   = blocked ? SW'(1) : '0;
         end
         S_WAIT: begin
            state_d = !blocked ? S_IDLE : (cnt_q == SW'(STARVE_LIMIT - 1)) ? S_FORCE : S_WAIT;
            cnt_d   = (!blocked || (cnt_q == SW'(STARVE_LIMIT - 1))) ? '0 : cnt_q + SW'(1);
         end
         S_FORCE: begin
            state_d = blocked ? S_WAIT : S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Starvation FSM output: the bubble request is the registered FORCE state
   always_comb wbStall = (state_q == S_FORCE);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenario tests for regfile_write_arbiter
module tb_regfile_write_arbiter;
   logic        clk = 1'b0;
   logic        rstn;
   logic        wbValid;
   logic [4:0]  wbRd;
   logic [31:0] wbData;
   logic        auxValid;
   logic        auxReady;
   logic [4:0]  auxRd;
   logic [31:0] auxData;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic [31:0] pendMask;
   logic        wbStall;
   logic [2:0]  fifoCount;
   logic [31:0] rf [32];
   int          errors = 0;
   int          checks = 0;

   regfile_write_arbiter dut (
      .clk(clk), .rstn(rstn),
      .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData),
      .auxValid(auxValid), .auxReady(auxReady), .auxRd(auxRd), .auxData(auxData),
      .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
      .pendMask(pendMask), .wbStall(wbStall), .fifoCount(fifoCount)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (regWrite) rf[writeReg] <= writeData;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite got=%0b exp=0", regWrite); end
      checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_writeReg got=%0d exp=0", writeReg); end
      checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_writeData got=%h exp=0", writeData); end
      checks++; if (pendMask !== 32'd0) begin errors++; $display("FAIL reset_pendMask got=%h exp=0", pendMask); end
      checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL reset_fifoCount got=%0d exp=0", fifoCount); end
      checks++; if (wbStall !== 1'b0) begin errors++; $display("FAIL reset_wbStall got=%0b exp=0", wbStall); end
      checks++; if (auxReady !== 1'b0) begin errors++; $display("FAIL reset_auxReady got=%0b exp=0", auxReady); end
      rstn = 1'b1;
      step();
      checks++; if (auxReady !== 1'b1) begin errors++; $display("FAIL post_reset_auxReady got=%0b exp=1", auxReady); end
   endtask

   task automatic test_wb_only;
      wbValid = 1'b1; wbRd = 5'd5; wbData = 32'hDEADBEEF;
      step();
      checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd5, 32'hDEADBEEF})
         begin errors++; $display("FAIL wb_write got=%0b/%0d/%h exp=1/5/deadbeef", regWrite, writeReg, writeData); end
      wbRd = 5'd0; wbData = 32'h1234;
      step();
      checks++; if ({regWrite, writeReg, writeData} !== {1'b0, 5'd0, 32'h1234})
         begin errors++; $display("FAIL wb_x0 got=%0b/%0d/%h exp=0/0/1234", regWrite, writeReg, writeData); end
      wbValid = 1'b0;
      step();
      checks++; if ({regWrite, writeReg, writeData} !== {1'b0, 5'd0, 32'h1234})
         begin errors++; $display("FAIL idle_hold got=%0b/%0d/%h exp=0/0/1234", regWrite, writeReg, writeData); end
   endtask

   task automatic test_aux_idle;
      auxValid = 1'b1; auxRd = 5'd7; auxData = 32'h11;
      step();
      auxValid = 1'b0;
      checks++; if (pendMask !== 32'h80) begin errors++; $display("FAIL aux_pend got=%h exp=80", pendMask); end
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL aux_early_write got=%0b exp=0", regWrite); end
      checks++; if (fifoCount !== 3'd1) begin errors++; $display("FAIL aux_count got=%0d exp=1", fifoCount); end
      step();
      checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd7, 32'h11})
         begin errors++; $display("FAIL aux_write got=%0b/%0d/%h exp=1/7/11", regWrite, writeReg, writeData); end
      checks++; if (pendMask !== 32'h0) begin errors++; $display("FAIL aux_pend_clear got=%h exp=0", pendMask); end
      checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL aux_count_clear got=%0d exp=0", fifoCount); end
   endtask

   task automatic test_fill;
      wbValid = 1'b1; wbRd = 5'd1; wbData = 32'h100;
      auxValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         auxRd = 5'(10 + i); auxData = 32'h200 + i;
         step();
      end
      auxValid = 1'b0;
      checks++; if (fifoCount !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", fifoCount); end
      checks++; if (auxReady !== 1'b0) begin errors++; $display("FAIL fill_ready got=%0b exp=0", auxReady); end
      checks++; if (pendMask !== 32'h3C00) begin errors++; $display("FAIL fill_pend got=%h exp=3c00", pendMask); end
      wbValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'(10 + i), 32'h200 + i})
            begin errors++; $display("FAIL drain_%0d got=%0b/%0d/%h exp=1/%0d/%h", i, regWrite, writeReg, writeData, 10 + i, 32'h200 + i); end
         checks++; if (fifoCount !== 3'(3 - i)) begin errors++; $display("FAIL drain_count_%0d got=%0d exp=%0d", i, fifoCount, 3 - i); end
         checks++; if (auxReady !== 1'b1) begin errors++; $display("FAIL drain_ready_%0d got=%0b exp=1", i, auxReady); end
      end
   endtask

   task automatic test_kill;
      auxValid = 1'b1; auxRd = 5'd3; auxData = 32'hA;
      step();
      auxValid = 1'b0;
      wbValid = 1'b1; wbRd = 5'd3; wbData = 32'hB;
      step();
      wbValid = 1'b0;
      checks++; if (pendMask !== 32'h0) begin errors++; $display("FAIL kill_pend got=%h exp=0", pendMask); end
      checks++; if (fifoCount !== 3'd1) begin errors++; $display("FAIL kill_count got=%0d exp=1", fifoCount); end
      checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd3, 32'hB})
         begin errors++; $display("FAIL kill_wb got=%0b/%0d/%h exp=1/3/b", regWrite, writeReg, writeData); end
      step();
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL kill_dead_pop got=%0b exp=0", regWrite); end
      checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL kill_pop_count got=%0d exp=0", fifoCount); end
      step();
      checks++; if (rf[3] !== 32'hB) begin errors++; $display("FAIL kill_rf got=%h exp=b", rf[3]); end
      wbValid = 1'b1; wbRd = 5'd4; wbData = 32'hC;
      auxValid = 1'b1; auxRd = 5'd4; auxData = 32'hD;
      step();
      wbValid = 1'b0; auxValid = 1'b0;
      checks++; if (pendMask !== 32'h10) begin errors++; $display("FAIL same_cycle_pend got=%h exp=10", pendMask); end
      step();
      checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd4, 32'hD})
         begin errors++; $display("FAIL same_cycle_pop got=%0b/%0d/%h exp=1/4/d", regWrite, writeReg, writeData); end
      step();
      checks++; if (rf[4] !== 32'hD) begin errors++; $display("FAIL same_cycle_rf got=%h exp=d", rf[4]); end
   endtask

   task automatic test_starvation;
      wbValid = 1'b1; wbRd = 5'd1; wbData = 32'h1;
      auxValid = 1'b1; auxRd = 5'd9; auxData = 32'h99;
      step();
      auxValid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++; if (wbStall !== (k == 8)) begin errors++; $display("FAIL starve_a_%0d got=%0b exp=%0b", k, wbStall, k == 8); end
      end
      step();
      checks++; if (wbStall !== 1'b0) begin errors++; $display("FAIL starve_one_cycle got=%0b exp=0", wbStall); end
      checks++; if (fifoCount !== 3'd1) begin errors++; $display("FAIL starve_ignored_count got=%0d exp=1", fifoCount); end
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++; if (wbStall !== (k == 8)) begin errors++; $display("FAIL starve_b_%0d got=%0b exp=%0b", k, wbStall, k == 8); end
      end
      wbValid = 1'b0;
      step();
      checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd9, 32'h99})
         begin errors++; $display("FAIL starve_drain got=%0b/%0d/%h exp=1/9/99", regWrite, writeReg, writeData); end
      checks++; if (wbStall !== 1'b0) begin errors++; $display("FAIL starve_release got=%0b exp=0", wbStall); end
      checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL starve_count got=%0d exp=0", fifoCount); end
      step();
      checks++; if (wbStall !== 1'b0) begin errors++; $display("FAIL starve_idle got=%0b exp=0", wbStall); end
   endtask

   task automatic test_async_reset;
      wbValid = 1'b1; wbRd = 5'd1; wbData = 32'h5;
      auxValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         auxRd = 5'(20 + i); auxData = 32'h300 + i;
         step();
      end
      auxValid = 1'b0; wbValid = 1'b0;
      step();
      checks++; if ({regWrite, writeReg, fifoCount} !== {1'b1, 5'd20, 3'd3})
         begin errors++; $display("FAIL pre_reset got=%0b/%0d/%0d exp=1/20/3", regWrite, writeReg, fifoCount); end
      #2 rstn = 1'b0;
      #1;
      checks++; if ({regWrite, writeReg, writeData} !== {1'b0, 5'd0, 32'd0})
         begin errors++; $display("FAIL async_port got=%0b/%0d/%h exp=0/0/0", regWrite, writeReg, writeData); end
      checks++; if ({fifoCount, pendMask, wbStall, auxReady} !== {3'd0, 32'd0, 1'b0, 1'b0})
         begin errors++; $display("FAIL async_state got=%0d/%h/%0b/%0b exp=0/0/0/0", fifoCount, pendMask, wbStall, auxReady); end
      step();
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({regWrite, fifoCount} !== {1'b0, 3'd0})
            begin errors++; $display("FAIL stale_%0d got=%0b/%0d exp=0/0", i, regWrite, fifoCount); end
      end
   endtask

   initial begin
      rstn = 1'b0; wbValid = 1'b0; wbRd = '0; wbData = '0;
      auxValid = 1'b0; auxRd = '0; auxData = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_wb_only();
      test_aux_idle();
      test_fill();
      test_kill();
      test_starvation();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
